// File: rtl/prio_dispatch.sv
// prio_dispatch
//   Collects one-cycle command pulses from four ports. Each port can hold one
//   pending op. A round-robin arbiter moves one pending op per cycle into a
//   single dispatch slot. The slot presents the op to either the add/sub unit
//   or the shift unit over a valid/ready handshake. Invalid commands are
//   bounced back as a one-cycle inv_valid/inv_tag pulse and are never queued.
//   All state changes on the falling edge of c_clk. Reset is synchronous and
//   active-high.
// Ports
//   c_clk, reset                  clock (negedge) and synchronous reset
//   req_cmd/tag/data1/data2       per-port command inputs; port p uses slice p
//   add_ready, shift_ready        downstream units accept the slot this edge
//   add_valid, shift_valid        slot holds an add/sub op or a shift op
//   out_cmd/data1/data2/port/tag  slot contents
//   inv_valid, inv_tag            per-port pulse for a rejected (invalid) command
//   drop                          per-port pulse: command lost, port was busy
module prio_dispatch #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2
) (
    input  logic                  c_clk,
    input  logic                  reset,
    input  logic [0:15]           req_cmd,
    input  logic [0:4*TAG_W-1]    req_tag,
    input  logic [0:4*DATA_W-1]   req_data1,
    input  logic [0:4*DATA_W-1]   req_data2,
    input  logic                  add_ready,
    input  logic                  shift_ready,
    output logic                  add_valid,
    output logic                  shift_valid,
    output logic [0:3]            out_cmd,
    output logic [0:DATA_W-1]     out_data1,
    output logic [0:DATA_W-1]     out_data2,
    output logic [0:1]            out_port,
    output logic [0:TAG_W-1]      out_tag,
    output logic [0:3]            inv_valid,
    output logic [0:4*TAG_W-1]    inv_tag,
    output logic [0:3]            drop
);

    function automatic logic is_add(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2);
    endfunction

    function automatic logic is_shift(input logic [3:0] c);
        return (c == 4'd5) || (c == 4'd6);
    endfunction

    // Per-port pending storage
    logic [3:0]                    pend_vld_q;
    logic [3:0][3:0]               pend_cmd_q;
    logic [3:0][TAG_W-1:0]         pend_tag_q;
    logic [3:0][DATA_W-1:0]        pend_d1_q;
    logic [3:0][DATA_W-1:0]        pend_d2_q;

    // Dispatch slot. The two valid flags are mutually exclusive by construction.
    logic                          add_vld_q;
    logic                          shf_vld_q;
    logic [3:0]                    slot_cmd_q;
    logic [DATA_W-1:0]             slot_d1_q;
    logic [DATA_W-1:0]             slot_d2_q;
    logic [1:0]                    slot_port_q;
    logic [TAG_W-1:0]              slot_tag_q;

    logic [1:0]                    rr_q;
    logic [3:0]                    inv_q;
    logic [3:0][TAG_W-1:0]         inv_tag_q;
    logic [3:0]                    drop_q;

    // Arbitration / decode
    logic                          xfer;
    logic                          gnt_d;
    logic [1:0]                    win_d;
    logic [1:0]                    idx;
    logic [3:0][3:0]               pc;
    logic [3:0]                    pv;
    logic [3:0]                    pinv;
    logic [3:0]                    freed;
    logic [3:0]                    cap_d;
    logic [3:0]                    drop_d;

    always_comb begin
        xfer  = (add_vld_q & add_ready) | (shf_vld_q & shift_ready);
        gnt_d = 1'b0;
        win_d = rr_q;
        idx   = rr_q;
        // Scan from the farthest offset down so the last hit is the port
        // closest to rr_q, i.e. the round-robin winner.
        for (int k = 3; k >= 0; k--) begin
            idx = rr_q + k[1:0];
            if (pend_vld_q[idx]) begin
                gnt_d = ~(add_vld_q | shf_vld_q) | xfer;
                win_d = idx;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            pc[p]     = req_cmd[4*p +: 4];
            pv[p]     = is_add(pc[p]) | is_shift(pc[p]);
            pinv[p]   = (pc[p] != 4'd0) & ~pv[p];
            // A port whose pending op is granted this edge may be refilled
            // on the same edge.
            freed[p]  = gnt_d & (win_d == 2'(p));
            cap_d[p]  = pv[p] & (~pend_vld_q[p] | freed[p]);
            drop_d[p] = pv[p] & pend_vld_q[p] & ~freed[p];
        end
    end

    always_ff @(negedge c_clk) begin
        if (reset) begin
            pend_vld_q  <= '0;
            pend_cmd_q  <= '0;
            pend_tag_q  <= '0;
            pend_d1_q   <= '0;
            pend_d2_q   <= '0;
            add_vld_q   <= 1'b0;
            shf_vld_q   <= 1'b0;
            slot_cmd_q  <= '0;
            slot_d1_q   <= '0;
            slot_d2_q   <= '0;
            slot_port_q <= '0;
            slot_tag_q  <= '0;
            rr_q        <= '0;
            inv_q       <= '0;
            inv_tag_q   <= '0;
            drop_q      <= '0;
        end else begin
            if (gnt_d) begin
                add_vld_q   <= is_add(pend_cmd_q[win_d]);
                shf_vld_q   <= is_shift(pend_cmd_q[win_d]);
                slot_cmd_q  <= pend_cmd_q[win_d];
                slot_d1_q   <= pend_d1_q[win_d];
                slot_d2_q   <= pend_d2_q[win_d];
                slot_tag_q  <= pend_tag_q[win_d];
                slot_port_q <= win_d;
                rr_q        <= win_d + 2'd1;
            end else if (xfer) begin
                add_vld_q <= 1'b0;
                shf_vld_q <= 1'b0;
            end

            for (int p = 0; p < 4; p++) begin
                drop_q[p]    <= drop_d[p];
                inv_q[p]     <= pinv[p];
                inv_tag_q[p] <= pinv[p] ? req_tag[TAG_W*p +: TAG_W] : '0;
                if (cap_d[p]) begin
                    pend_vld_q[p] <= 1'b1;
                    pend_cmd_q[p] <= pc[p];
                    pend_tag_q[p] <= req_tag[TAG_W*p +: TAG_W];
                    pend_d1_q[p]  <= req_data1[DATA_W*p +: DATA_W];
                    pend_d2_q[p]  <= req_data2[DATA_W*p +: DATA_W];
                end else if (freed[p]) begin
                    pend_vld_q[p] <= 1'b0;
                end
            end
        end
    end

    assign add_valid   = add_vld_q;
    assign shift_valid = shf_vld_q;
    assign out_cmd     = slot_cmd_q;
    assign out_data1   = slot_d1_q;
    assign out_data2   = slot_d2_q;
    assign out_port    = slot_port_q;
    assign out_tag     = slot_tag_q;

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            inv_valid[p]                 = inv_q[p];
            drop[p]                      = drop_q[p];
            inv_tag[TAG_W*p +: TAG_W]    = inv_tag_q[p];
        end
    end

endmodule

// File: tb/tb_prio_dispatch.sv
// Bench for prio_dispatch: directed table, hand-written multi-cycle sequences,
// then random traffic against a behavioural model.
module tb_prio_dispatch;

    logic          c_clk = 1'b0;
    logic          reset;
    logic [0:15]   req_cmd;
    logic [0:7]    req_tag;
    logic [0:127]  req_data1;
    logic [0:127]  req_data2;
    logic          add_ready;
    logic          shift_ready;
    logic          add_valid;
    logic          shift_valid;
    logic [0:3]    out_cmd;
    logic [0:31]   out_data1;
    logic [0:31]   out_data2;
    logic [0:1]    out_port;
    logic [0:1]    out_tag;
    logic [0:3]    inv_valid;
    logic [0:7]    inv_tag;
    logic [0:3]    drop;

    prio_dispatch #(.DATA_W(32), .TAG_W(2)) dut (
        .c_clk(c_clk), .reset(reset),
        .req_cmd(req_cmd), .req_tag(req_tag),
        .req_data1(req_data1), .req_data2(req_data2),
        .add_ready(add_ready), .shift_ready(shift_ready),
        .add_valid(add_valid), .shift_valid(shift_valid),
        .out_cmd(out_cmd), .out_data1(out_data1), .out_data2(out_data2),
        .out_port(out_port), .out_tag(out_tag),
        .inv_valid(inv_valid), .inv_tag(inv_tag), .drop(drop)
    );

    always #5 c_clk = ~c_clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_pend [4];
    logic [3:0]  m_pc   [4];
    logic [1:0]  m_pt   [4];
    logic [31:0] m_p1   [4];
    logic [31:0] m_p2   [4];
    logic        m_sv;
    logic [3:0]  m_sc;
    logic [1:0]  m_sp, m_st;
    logic [31:0] m_s1, m_s2;
    int          m_rr;
    logic        m_inv  [4];
    logic        m_drop [4];
    logic [1:0]  m_it   [4];

    function automatic logic op_add(input logic [3:0] c);
        return c inside {4'd1, 4'd2};
    endfunction
    function automatic logic op_shf(input logic [3:0] c);
        return c inside {4'd5, 4'd6};
    endfunction

    task automatic model_step();
        logic xf;
        int   win;
        logic [3:0] c;
        if (reset) begin
            for (int p = 0; p < 4; p++) begin
                m_pend[p] = 0; m_inv[p] = 0; m_drop[p] = 0; m_it[p] = 0;
            end
            m_sv = 0; m_rr = 0;
            return;
        end
        xf  = m_sv && ((op_add(m_sc) && add_ready) || (op_shf(m_sc) && shift_ready));
        win = -1;
        if (!m_sv || xf)
            for (int k = 0; k < 4; k++)
                if (win < 0 && m_pend[(m_rr + k) % 4]) win = (m_rr + k) % 4;
        if (win >= 0) begin
            m_sv = 1; m_sc = m_pc[win]; m_st = m_pt[win];
            m_s1 = m_p1[win]; m_s2 = m_p2[win]; m_sp = 2'(win);
            m_rr = (win + 1) % 4;
            m_pend[win] = 0;
        end else if (xf) begin
            m_sv = 0;
        end
        for (int p = 0; p < 4; p++) begin
            c = req_cmd[4*p +: 4];
            m_inv[p] = 0; m_drop[p] = 0; m_it[p] = 0;
            if (c != 0) begin
                if (op_add(c) || op_shf(c)) begin
                    if (!m_pend[p]) begin
                        m_pend[p] = 1; m_pc[p] = c; m_pt[p] = req_tag[2*p +: 2];
                        m_p1[p] = req_data1[32*p +: 32]; m_p2[p] = req_data2[32*p +: 32];
                    end else begin
                        m_drop[p] = 1;
                    end
                end else begin
                    m_inv[p] = 1; m_it[p] = req_tag[2*p +: 2];
                end
            end
        end
    endtask

    task automatic check_model(input int cyc);
        chk($sformatf("c%0d add_valid", cyc), add_valid, m_sv && op_add(m_sc));
        chk($sformatf("c%0d shift_valid", cyc), shift_valid, m_sv && op_shf(m_sc));
        if (m_sv) begin
            chk($sformatf("c%0d out_cmd", cyc), out_cmd, m_sc);
            chk($sformatf("c%0d out_port", cyc), out_port, m_sp);
            chk($sformatf("c%0d out_tag", cyc), out_tag, m_st);
            chk($sformatf("c%0d out_data1", cyc), out_data1, m_s1);
            chk($sformatf("c%0d out_data2", cyc), out_data2, m_s2);
        end
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("c%0d inv_valid[%0d]", cyc, p), inv_valid[p], m_inv[p]);
            chk($sformatf("c%0d drop[%0d]", cyc, p), drop[p], m_drop[p]);
            if (m_inv[p]) chk($sformatf("c%0d inv_tag[%0d]", cyc, p), inv_tag[2*p +: 2], m_it[p]);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_port(input int p, input logic [3:0] c, input logic [1:0] t,
                            input logic [31:0] a, input logic [31:0] b);
        req_cmd[4*p +: 4]    = c;
        req_tag[2*p +: 2]    = t;
        req_data1[32*p +: 32] = a;
        req_data2[32*p +: 32] = b;
    endtask

    task automatic clr_cmd();
        req_cmd = '0;
    endtask

    // Inputs are set at a rising edge; the DUT updates on the next falling
    // edge; we return at the following rising edge to sample.
    task automatic tick();
        model_step();
        @(posedge c_clk);
    endtask

    task automatic chk_slot(input string nm, input logic ea, input logic es, input logic [1:0] ep);
        chk({nm, " add_valid"}, add_valid, ea);
        chk({nm, " shift_valid"}, shift_valid, es);
        if (ea || es) chk({nm, " out_port"}, out_port, ep);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " add_valid"}, add_valid, 0);
        chk({nm, " shift_valid"}, shift_valid, 0);
        chk({nm, " out_cmd"}, out_cmd, 0);
        chk({nm, " out_data1"}, out_data1, 0);
        chk({nm, " out_data2"}, out_data2, 0);
        chk({nm, " out_port"}, out_port, 0);
        chk({nm, " out_tag"}, out_tag, 0);
        chk({nm, " inv_valid"}, inv_valid, 0);
        chk({nm, " inv_tag"}, inv_tag, 0);
        chk({nm, " drop"}, drop, 0);
    endtask

    // ---------------- directed table ----------------
    // Expectations in row r describe outputs seen before row r's inputs apply.
    typedef struct {
        int          port;
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] d1, d2;
        logic        ar, sr;
        logic        e_add, e_shf;
        logic [3:0]  e_cmd;
        logic [1:0]  e_port, e_tag;
        logic [31:0] e_d1, e_d2;
        logic [3:0]  e_inv, e_drop;   // bit p = port p
        logic [1:0]  e_itag;
    } vec_t;

    localparam int NV = 18;
    vec_t tv [NV];

    task automatic check_row(input int r);
        string nm;
        nm = $sformatf("row%0d", r);
        chk({nm, " add_valid"}, add_valid, tv[r].e_add);
        chk({nm, " shift_valid"}, shift_valid, tv[r].e_shf);
        if (tv[r].e_add || tv[r].e_shf) begin
            chk({nm, " out_cmd"}, out_cmd, tv[r].e_cmd);
            chk({nm, " out_port"}, out_port, tv[r].e_port);
            chk({nm, " out_tag"}, out_tag, tv[r].e_tag);
            chk({nm, " out_data1"}, out_data1, tv[r].e_d1);
            chk({nm, " out_data2"}, out_data2, tv[r].e_d2);
        end
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("%s inv_valid[%0d]", nm, p), inv_valid[p], tv[r].e_inv[p]);
            chk($sformatf("%s drop[%0d]", nm, p), drop[p], tv[r].e_drop[p]);
            if (tv[r].e_inv[p]) chk($sformatf("%s inv_tag[%0d]", nm, p), inv_tag[2*p +: 2], tv[r].e_itag);
        end
    endtask

    initial begin
        logic [3:0] c;
        // single add from port 0: visible two edges later for one cycle
        tv[0]  = '{0, 4'd1, 2'd2, 32'd10, 32'd12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{0, 4'd0, 2'd0, 32'd0,  32'd0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[2]  = '{0, 4'd0, 2'd0, 32'd0,  32'd0,  1, 0, 1, 0, 4'd1, 2'd0, 2'd2, 32'd10, 32'd12, 0, 0, 0};
        // stalled add on port 2, refill to pending, third cmd dropped
        tv[3]  = '{2, 4'd2, 2'd3, 32'd7,  32'd3,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[4]  = '{0, 4'd0, 2'd0, 32'd0,  32'd0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[5]  = '{2, 4'd2, 2'd1, 32'd20, 32'd5,  0, 0, 1, 0, 4'd2, 2'd2, 2'd3, 32'd7, 32'd3, 0, 0, 0};
        tv[6]  = '{2, 4'd1, 2'd0, 32'd1,  32'd1,  0, 0, 1, 0, 4'd2, 2'd2, 2'd3, 32'd7, 32'd3, 0, 0, 0};
        tv[7]  = '{0, 4'd0, 2'd0, 32'd0,  32'd0,  0, 0, 1, 0, 4'd2, 2'd2, 2'd3, 32'd7, 32'd3, 0, 4'b0100, 0};
        tv[8]  = '{0, 4'd0, 2'd0, 32'd0,  32'd0,  1, 0, 1, 0, 4'd2, 2'd2, 2'd3, 32'd7, 32'd3, 0, 0, 0};
        tv[9]  = '{0, 4'd0, 2'd0, 32'd0,  32'd0,  0, 0, 1, 0, 4'd2, 2'd2, 2'd1, 32'd20, 32'd5, 0, 0, 0};
        tv[10] = '{0, 4'd0, 2'd0, 32'd0,  32'd0,  1, 0, 1, 0, 4'd2, 2'd2, 2'd1, 32'd20, 32'd5, 0, 0, 0};
        tv[11] = '{0, 4'd0, 2'd0, 32'd0,  32'd0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        // invalid commands bounce for one cycle, nothing dispatched
        tv[12] = '{3, 4'd15, 2'd1, 32'd9, 32'd9,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[13] = '{0, 4'd0, 2'd0, 32'd0,  32'd0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 0, 2'd1};
        tv[14] = '{0, 4'd0, 2'd0, 32'd0,  32'd0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[15] = '{0, 4'd3, 2'd2, 32'd4,  32'd4,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[16] = '{0, 4'd0, 2'd0, 32'd0,  32'd0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 2'd2};
        tv[17] = '{0, 4'd0, 2'd0, 32'd0,  32'd0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        reset = 1; req_cmd = '0; req_tag = '0; req_data1 = '0; req_data2 = '0;
        add_ready = 0; shift_ready = 0;
        @(posedge c_clk);
        tick(); tick();
        reset = 0;
        chk_zero("reset");

        for (int r = 0; r < NV; r++) begin
            check_row(r);
            clr_cmd();
            if (tv[r].cmd != 0) set_port(tv[r].port, tv[r].cmd, tv[r].tag, tv[r].d1, tv[r].d2);
            add_ready = tv[r].ar; shift_ready = tv[r].sr;
            tick();
        end

        // all four ports shift at once: grants 0,1,2,3, then pointer wraps
        reset = 1; clr_cmd(); tick(); reset = 0;
        add_ready = 0; shift_ready = 1;
        for (int p = 0; p < 4; p++) set_port(p, 4'd5, 2'(p), 32'(p), 32'(p + 1));
        tick(); clr_cmd();
        chk_slot("rr capture", 0, 0, 0); tick();
        for (int p = 0; p < 4; p++) begin
            chk_slot($sformatf("rr grant%0d", p), 0, 1, 2'(p));
            tick();
        end
        chk_slot("rr drained", 0, 0, 0);
        set_port(1, 4'd6, 2'd1, 32'd11, 32'd1); set_port(3, 4'd6, 2'd3, 32'd33, 32'd3);
        tick(); clr_cmd();
        chk_slot("rr2 capture", 0, 0, 0); tick();
        chk_slot("rr2 first", 0, 1, 2'd1); tick();
        chk_slot("rr2 second", 0, 1, 2'd3); tick();
        chk_slot("rr2 drained", 0, 0, 0);

        // same-edge transfer of a shift and grant of a pending add
        add_ready = 1; shift_ready = 0;
        set_port(0, 4'd5, 2'd1, 32'd8, 32'd2); tick(); clr_cmd();
        tick();
        chk_slot("xg shift held", 0, 1, 2'd0);
        set_port(1, 4'd1, 2'd2, 32'd5, 32'd6); tick(); clr_cmd();
        chk_slot("xg stalled", 0, 1, 2'd0);
        shift_ready = 1; tick();
        chk_slot("xg add next", 1, 0, 2'd1);
        chk("xg out_data1", out_data1, 32'd5);
        tick();
        chk_slot("xg drained", 0, 0, 0);

        // reset with a full slot and two pending ops
        add_ready = 0; shift_ready = 0;
        set_port(0, 4'd1, 2'd1, 32'd1, 32'd2); tick(); clr_cmd();
        set_port(1, 4'd2, 2'd1, 32'd3, 32'd4); set_port(2, 4'd1, 2'd2, 32'd5, 32'd6);
        tick(); clr_cmd();
        chk_slot("mid busy", 1, 0, 2'd0);
        reset = 1; add_ready = 1; shift_ready = 1; tick(); reset = 0;
        chk_zero("mid reset");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_slot($sformatf("post reset%0d", i), 0, 0, 0);
        end
        set_port(0, 4'd2, 2'd3, 32'd100, 32'd50); tick(); clr_cmd();
        chk_slot("post new cap", 0, 0, 0); tick();
        chk_slot("post new disp", 1, 0, 2'd0);
        chk("post new out_cmd", out_cmd, 4'd2);
        chk("post new out_data2", out_data2, 32'd50);
        tick();
        chk_slot("post drained", 0, 0, 0);

        // random traffic against the model
        reset = 1; clr_cmd(); tick(); reset = 0;
        for (int i = 0; i < 800; i++) begin
            check_model(i);
            clr_cmd();
            for (int p = 0; p < 4; p++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 4)      c = 4'd0;
                else if (r < 8) begin
                    case ($urandom_range(0, 3))
                        0: c = 4'd1;
                        1: c = 4'd2;
                        2: c = 4'd5;
                        default: c = 4'd6;
                    endcase
                end else if (r == 8) c = 4'd3;
                else            c = 4'($urandom_range(7, 15));
                set_port(p, c, 2'($urandom), $urandom, $urandom);
            end
            add_ready   = ($urandom_range(0, 3) != 0);
            shift_ready = ($urandom_range(0, 3) != 0);
            reset       = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 0;
        check_model(800);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
